// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter
// Shares one single-port, byte-enabled block RAM between the instruction
// fetch port (I) and the load/store port (D). One grant per cycle. The RAM
// read data returns one cycle after the grant and is routed to the port
// that owned the access.
//
// Optional build macro: MISALIGN_CHECK_EN
//   When defined, a misaligned half/word D access is granted but suppressed:
//   no byte enables and no write reach the RAM. Its completion returns zero
//   data and raises d_misalign for one cycle.
//   When undefined, the d_misalign port does not exist. Misaligned accesses
//   truncate the low address bits and follow the normal lane rules.

module imem_dmem_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int STARVE_LIMIT  = 4,
   parameter int CNT_WIDTH     = 4
) (
   input  logic                     clk,
   input  logic                     RESET,
   // instruction fetch port
   input  logic                     i_req,
   input  logic [ADDRESS_WIDTH-1:0] i_addr,
   output logic                     i_gnt,
   output logic                     i_rvalid,
   output logic [31:0]              i_rdata,
   // load/store port
   input  logic                     d_req,
   input  logic                     d_we,
   input  logic [1:0]               d_size,
   input  logic [ADDRESS_WIDTH-1:0] d_addr,
   input  logic [31:0]              d_wdata,
   output logic                     d_gnt,
   output logic                     d_rvalid,
   output logic [31:0]              d_rdata,
`ifdef MISALIGN_CHECK_EN
   output logic                     d_misalign,
`endif
   // block RAM side
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [3:0]               mem_be,
   output logic                     mem_we,
   output logic [31:0]              mem_wdata,
   input  logic [31:0]              mem_rdata
);

   // Encoding of the port that owns the response arriving next cycle
   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_I    = 2'd1;
   localparam logic [1:0] OWNER_D    = 2'd2;

   localparam logic [CNT_WIDTH-1:0] STARVE_LIMIT_C = CNT_WIDTH'(STARVE_LIMIT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX        = {CNT_WIDTH{1'b1}};

   // Registered state
   logic [CNT_WIDTH-1:0]     starve_cnt_reg, starve_cnt_next;
   logic [1:0]               owner_reg, owner_next;
   logic                     d_zero_reg, d_zero_next;
   logic                     misalign_reg, misalign_next;
   logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
   logic [31:0]              i_rdata_reg;
   logic [31:0]              d_rdata_reg;

   // Arbitration and lane decode
   logic        i_starved;
   logic        i_win;
   logic        d_win;
   logic        size_byte;
   logic        size_half;
   logic        d_bad;
   logic [1:0]  d_lane;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [31:0] d_resp_data;
   logic        unused_addr_bits;

   // Fetch word address bits [1:0] carry no information
   assign unused_addr_bits = ^i_addr[1:0];

   assign i_starved = (starve_cnt_reg >= STARVE_LIMIT_C);
   assign size_byte = (d_size == 2'd0);
   assign size_half = (d_size == 2'd1);
   assign d_lane    = d_addr[1:0];

`ifdef MISALIGN_CHECK_EN
   // Half on an odd byte, or word (sizes 2 and 3) off a word boundary
   assign d_bad = (size_half && d_addr[0]) ||
                  (!size_byte && !size_half && (d_addr[1:0] != 2'b00));
`else
   assign d_bad = 1'b0;
`endif

   // Grant selection: D wins by default, a starved I overrides it, and
   // nothing is granted while reset is held.
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (!RESET) begin
         i_win = i_req && (!d_req || i_starved);
         d_win = d_req && !i_win;
      end
   end

   assign i_gnt = i_win;
   assign d_gnt = d_win;

   // Per-lane byte enable and replicated write data for SB/SH/SW
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         assign lane_be[gi] = size_byte ? (d_lane == LANE) :
                              size_half ? (d_lane[1] == LANE[1]) :
                                          1'b1;
         assign lane_wdata[8*gi +: 8] = size_byte ? d_wdata[7:0] :
                                        size_half ? d_wdata[8*(gi%2) +: 8] :
                                                    d_wdata[8*gi +: 8];
      end
   endgenerate

   // RAM command for the granted port; idle cycles keep the last address
   always_comb begin
      mem_addr  = addr_reg;
      mem_be    = 4'b0000;
      mem_we    = 1'b0;
      mem_wdata = 32'h0000_0000;
      if (i_win) begin
         mem_addr = {i_addr[ADDRESS_WIDTH-1:2], 2'b00};
         mem_be   = 4'b1111;
      end else if (d_win) begin
         mem_addr = {d_addr[ADDRESS_WIDTH-1:2], 2'b00};
         if (d_bad) begin
            mem_be = 4'b0000;
            mem_we = 1'b0;
         end else if (d_we) begin
            mem_be    = lane_be;
            mem_we    = 1'b1;
            mem_wdata = lane_wdata;
         end else begin
            mem_be = 4'b1111;
         end
      end
   end

   // Next-state: response owner, data suppression, starvation count
   always_comb begin
      owner_next      = OWNER_NONE;
      d_zero_next     = 1'b0;
      misalign_next   = 1'b0;
      starve_cnt_next = '0;
      addr_next       = mem_addr;
      if (i_win) begin
         owner_next = OWNER_I;
      end else if (d_win) begin
         owner_next    = OWNER_D;
         d_zero_next   = d_we || d_bad;
         misalign_next = d_bad;
      end
      if (i_req && !i_win) begin
         starve_cnt_next = (starve_cnt_reg == CNT_MAX) ? starve_cnt_reg
                                                       : starve_cnt_reg + 1'b1;
      end
   end

   // Grant bookkeeping registers; reset drops any response in flight
   always_ff @(posedge clk) begin
      if (RESET) begin
         owner_reg      <= OWNER_NONE;
         d_zero_reg     <= 1'b0;
         misalign_reg   <= 1'b0;
         starve_cnt_reg <= '0;
         addr_reg       <= '0;
      end else begin
         owner_reg      <= owner_next;
         d_zero_reg     <= d_zero_next;
         misalign_reg   <= misalign_next;
         starve_cnt_reg <= starve_cnt_next;
         addr_reg       <= addr_next;
      end
   end

   // Response routing: RAM data goes straight out on the valid cycle
   assign i_rvalid    = (owner_reg == OWNER_I);
   assign d_rvalid    = (owner_reg == OWNER_D);
   assign d_resp_data = d_zero_reg ? 32'h0000_0000 : mem_rdata;
   assign i_rdata     = i_rvalid ? mem_rdata : i_rdata_reg;
   assign d_rdata     = d_rvalid ? d_resp_data : d_rdata_reg;

`ifdef MISALIGN_CHECK_EN
   assign d_misalign = d_rvalid && misalign_reg;
`else
   // Without the check the flag has no consumer
   logic unused_misalign;
   assign unused_misalign = misalign_reg;
`endif

   // Capture delivered words so read data holds between responses
   always_ff @(posedge clk) begin
      if (RESET) begin
         i_rdata_reg <= 32'h0000_0000;
         d_rdata_reg <= 32'h0000_0000;
      end else begin
         if (i_rvalid) begin
            i_rdata_reg <= mem_rdata;
         end
         if (d_rvalid) begin
            d_rdata_reg <= d_resp_data;
         end
      end
   end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter
// Directed stimulus against imem_dmem_arbiter with a behavioural RAM behind
// it. A reference model (grant rule, byte-level memory image, pending
// response) is compared with the DUT on every cycle, and a few literal
// expectations pin the key scenarios.

module tb_imem_dmem_arbiter;

   localparam int AW    = 32;
   localparam int LIMIT = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt, i_rvalid;
   logic [31:0]   i_rdata;
   logic          d_req, d_we;
   logic [1:0]    d_size;
   logic [AW-1:0] d_addr;
   logic [31:0]   d_wdata;
   logic          d_gnt, d_rvalid;
   logic [31:0]   d_rdata;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;
`ifdef MISALIGN_CHECK_EN
   logic          d_misalign;
`endif

   always #5 clk = ~clk;

   imem_dmem_arbiter #(.ADDRESS_WIDTH(AW), .STARVE_LIMIT(LIMIT), .CNT_WIDTH(4)) dut (
      .clk(clk), .RESET(rst),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
`ifdef MISALIGN_CHECK_EN
      .d_misalign(d_misalign),
`endif
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Behavioural block RAM driven by the arbiter bus
   logic [31:0] ram [0:255];
   always @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
      mem_rdata <= ram[mem_addr[9:2]];
   end

   // Reference model state
   logic [31:0]   model_mem [0:255];
   int            starve;
   bit            pend_i, pend_d, pend_mis;
   logic [31:0]   pend_data;
   logic [31:0]   hold_i, hold_d;
   logic [AW-1:0] last_addr;
   bit            check_en, trace_en;
   string         trace;
   int            cycle;
   int            checks, failures;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit misaligned(input logic [1:0] sz, input logic [AW-1:0] a);
`ifdef MISALIGN_CHECK_EN
      return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   // Store the size-many low bytes of wd at the address rounded down to size
   task automatic model_store(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] wd);
      int nb;
      int base;
      int ba;
      nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      base = int'(a[9:0]) & ~(nb - 1);
      for (int k = 0; k < nb; k++) begin
         ba = base + k;
         model_mem[(ba >> 2) & 255][8*(ba & 3) +: 8] = wd[8*k +: 8];
      end
   endtask

   // Per-cycle comparison against the model, then model update
   always @(negedge clk) begin
      if (check_en) begin
         bit            eg_i, eg_d, bad;
         logic [3:0]    e_be;
         logic [31:0]   e_wd;
         logic [AW-1:0] e_addr;
         cycle++;
         eg_i = !rst && i_req && (!d_req || starve >= LIMIT);
         eg_d = !rst && d_req && !eg_i;
         bad  = eg_d && misaligned(d_size, d_addr);
         chk("i_gnt", 32'(i_gnt), 32'(eg_i));
         chk("d_gnt", 32'(d_gnt), 32'(eg_d));
         chk("i_rvalid", 32'(i_rvalid), 32'(pend_i));
         chk("d_rvalid", 32'(d_rvalid), 32'(pend_d));
         chk("i_rdata", i_rdata, pend_i ? pend_data : hold_i);
         chk("d_rdata", d_rdata, pend_d ? pend_data : hold_d);
`ifdef MISALIGN_CHECK_EN
         chk("d_misalign", 32'(d_misalign), 32'(pend_d && pend_mis));
`endif
         e_addr = last_addr; e_be = 4'b0000; e_wd = 32'h0;
         if (eg_i) begin
            e_addr = {i_addr[AW-1:2], 2'b00}; e_be = 4'b1111;
         end else if (eg_d) begin
            e_addr = {d_addr[AW-1:2], 2'b00};
            if (bad)           e_be = 4'b0000;
            else if (!d_we)    e_be = 4'b1111;
            else if (d_size == 2'd0) begin e_be = 4'b0001 << d_addr[1:0]; e_wd = {4{d_wdata[7:0]}}; end
            else if (d_size == 2'd1) begin e_be = d_addr[1] ? 4'b1100 : 4'b0011; e_wd = {2{d_wdata[15:0]}}; end
            else begin e_be = 4'b1111; e_wd = d_wdata; end
         end
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_be", 32'(mem_be), 32'(e_be));
         chk("mem_we", 32'(mem_we), 32'(eg_d && d_we && !bad));
         if (eg_d && d_we && !bad) chk("mem_wdata", mem_wdata, e_wd);
         if (trace_en) trace = {trace, eg_i ? "I" : eg_d ? "D" : "-"};
         if (eg_i || eg_d)
            $display("cycle %0d grant=%s addr=%h we=%0d be=%b", cycle, eg_i ? "I" : "D",
                     mem_addr, mem_we, mem_be);
         // advance the model by one clock edge
         if (rst) begin
            hold_i = 0; hold_d = 0;
         end else begin
            if (pend_i) hold_i = pend_data;
            if (pend_d) hold_d = pend_data;
         end
         pend_i = eg_i; pend_d = eg_d; pend_mis = bad;
         pend_data = 32'h0;
         if (eg_i) pend_data = model_mem[i_addr[9:2]];
         if (eg_d && !d_we && !bad) pend_data = model_mem[d_addr[9:2]];
         if (eg_d && d_we && !bad) model_store(d_size, d_addr, d_wdata);
         if (rst) starve = 0;
         else if (i_req && !eg_i) starve = (starve == 15) ? 15 : starve + 1;
         else starve = 0;
         last_addr = rst ? '0 : (eg_i || eg_d) ? e_addr : last_addr;
      end
   end

   task automatic step(input bit r, input bit ir, input logic [AW-1:0] ia, input bit dr,
                       input bit we, input logic [1:0] sz, input logic [AW-1:0] da,
                       input logic [31:0] wd);
      @(posedge clk); #1;
      rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = we; d_size = sz; d_addr = da; d_wdata = wd;
   endtask

   task automatic idle();
      step(0, 0, 32'h0, 0, 0, 2'd0, 32'h0, 32'h0);
   endtask

   task automatic at_negedge();
      @(negedge clk); #1;
   endtask

   initial begin
      checks = 0; failures = 0; cycle = 0; trace = ""; trace_en = 0; check_en = 0;
      starve = 0; pend_i = 0; pend_d = 0; pend_mis = 0; pend_data = 0;
      hold_i = 0; hold_d = 0; last_addr = '0;
      for (int k = 0; k < 256; k++) begin
         ram[k] = 32'h1000_0000 + 32'(k * 32'h0101);
      end
      ram[4] = 32'hDEAD_BEEF; ram[16] = 32'h0BAD_F00D; ram[17] = 32'hC0FF_EE00;
      for (int k = 0; k < 256; k++) model_mem[k] = ram[k];
      rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0; d_wdata = 0;
      @(posedge clk); #1;
      check_en = 1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle();
      at_negedge();
      chk("reset_rvalid", 32'({i_rvalid, d_rvalid, i_gnt, d_gnt}), 32'h0);
      chk("reset_rdata", i_rdata | d_rdata, 32'h0);

      // single fetch
      step(0, 1, 32'h10, 0, 0, 0, 0, 0);
      at_negedge();
      chk("fetch_gnt_addr", mem_addr, 32'h10);
      idle();
      at_negedge();
      chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);

      // store byte, then read it back
      step(0, 0, 0, 1, 1, 2'd0, 32'h23, 32'hAB);
      at_negedge();
      chk("sb_be", 32'(mem_be), 32'h8);
      chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
      chk("sb_addr", mem_addr, 32'h20);
      idle();
      at_negedge();
      chk("sb_done", 32'({d_rvalid, d_rdata != 0}), 32'h2);
      step(0, 0, 0, 1, 0, 2'd0, 32'h20, 0);
      idle();

      // half and word stores (including an odd half), then loads back
      step(0, 0, 0, 1, 1, 2'd1, 32'h86, 32'h1234_5678);
      step(0, 0, 0, 1, 1, 2'd2, 32'h88, 32'hCAFE_0001);
      step(0, 0, 0, 1, 1, 2'd1, 32'h8D, 32'h0000_9999);
      step(0, 0, 0, 1, 0, 2'd0, 32'h84, 0);
      step(0, 0, 0, 1, 0, 2'd3, 32'h88, 0);
      step(0, 0, 0, 1, 0, 2'd1, 32'h8C, 0);
      idle();

      // back-to-back: D load then I fetch
      step(0, 0, 0, 1, 0, 2'd2, 32'h40, 0);
      step(0, 1, 32'h44, 0, 0, 0, 0, 0);
      at_negedge();
      chk("b2b_d_rdata", d_rdata, 32'h0BAD_F00D);
      idle();
      at_negedge();
      chk("b2b_i_rdata", i_rdata, 32'hC0FF_EE00);
      chk("b2b_hold_d", d_rdata, 32'h0BAD_F00D);

      // contention: both held for 10 cycles
      repeat (10) begin
         step(0, 1, 32'h10, 1, 0, 2'd2, 32'h40, 0);
         trace_en = 1;
      end
      idle();
      trace_en = 0;
      checks++;
      if (trace != "DDDDIDDDDI") begin
         failures++;
         $display("FAIL contention_pattern: got %s expected DDDDIDDDDI", trace);
      end
      trace = "";

      // reset during contention: no grant, no response, starvation cleared
      repeat (3) step(0, 1, 32'h10, 1, 0, 2'd2, 32'h40, 0);
      step(1, 1, 32'h10, 1, 0, 2'd2, 32'h44, 0);
      at_negedge();
      chk("rst_no_gnt", 32'({i_gnt, d_gnt}), 32'h0);
      idle();
      at_negedge();
      chk("rst_no_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
      repeat (5) begin
         step(0, 1, 32'h10, 1, 0, 2'd2, 32'h40, 0);
         trace_en = 1;
      end
      idle();
      trace_en = 0;
      checks++;
      if (trace != "DDDDI") begin
         failures++;
         $display("FAIL starve_after_reset: got %s expected DDDDI", trace);
      end

      // misaligned word store
      step(0, 0, 0, 1, 1, 2'd2, 32'h42, 32'h5555_AAAA);
      at_negedge();
`ifdef MISALIGN_CHECK_EN
      chk("mis_be_we", 32'({mem_we, mem_be}), 32'h0);
      idle();
      at_negedge();
      chk("mis_flag", 32'({d_misalign, d_rvalid}), 32'h3);
`else
      chk("mis_trunc_be_we", 32'({mem_we, mem_be}), 32'h1F);
      idle();
`endif
      step(0, 0, 0, 1, 0, 2'd2, 32'h40, 0);
      idle();
      idle();
      at_negedge();
      check_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish before 100us");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one single-port, byte-enabled program/data block RAM between the core's instruction-fetch port (I) and load/store port (D).
- RAM has a 1-cycle registered read.
- The arbiter does the following:
  - grants one requester per cycle;
  - builds byte enables and lane-shifted write data for SB/SH/SW;
  - routes the read word back to the granted port one cycle later.
- Sits between the core pipeline and the block RAM wrapper.

Parameters:
- ADDRESS_WIDTH, 32, byte-address width of both ports and mem_addr.
- STARVE_LIMIT, 4, consecutive cycles I may be denied before it gets forced priority; legal range 1..15.
- CNT_WIDTH, 4, width of the starvation counter.

Ports:
- clk  in  1  rising-edge clock
- RESET  in  1  synchronous active-high reset
- i_req  in  1  fetch request; held until i_gnt
- i_addr  in  ADDRESS_WIDTH  fetch byte address; bits [1:0] ignored
- i_gnt  out  1  fetch granted this cycle
- i_rvalid  out  1  i_rdata valid; asserted the cycle after i_gnt
- i_rdata  out  32  fetched word
- d_req  in  1  load/store request; held with stable fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- d_addr  in  ADDRESS_WIDTH  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  completion; asserted the cycle after d_gnt, for loads and stores
- d_rdata  out  32  raw aligned RAM word for loads; 0 for stores
- mem_addr  out  ADDRESS_WIDTH  byte address to RAM, bits [1:0] forced to 0
- mem_be  out  4  byte enables
- mem_we  out  1  write enable
- mem_wdata  out  32  lane-shifted write data
- mem_rdata  in  32  RAM registered read data

Behaviour:
- Arbitration is combinational in cycle N. At most one of i_gnt/d_gnt is high.
  - Default: D has priority over I.
  - Exception: when starve_cnt ≥ STARVE_LIMIT and i_req=1, I wins.
  - If only one port requests, it wins. If neither requests, mem_we=0, mem_be=0, mem_addr holds the last value.
- starve_cnt (registered):
  - +1 when i_req=1 and i_gnt=0, saturating at 2^CNT_WIDTH-1;
  - cleared when i_gnt=1 or i_req=0.
- Lane logic on a D grant:
  - byte: be = 1 << addr[1:0]; wdata = {4{d_wdata[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{d_wdata[15:0]}}.
  - word: be = 4'b1111; wdata = d_wdata.
  - Loads drive mem_be=4'b1111 and mem_we=0.
- I grants drive mem_we=0, mem_be=4'b1111, mem_addr={i_addr[31:2],2'b00}.
- Response state: a register owner ∈ {NONE, I, D} is latched at every edge from the grant.
  - Cycle N+1: owner=I gives i_rvalid=1 and i_rdata=mem_rdata; owner=D gives d_rvalid=1 and d_rdata=mem_rdata (or 0 if the latched op was a store).
  - Back-to-back grants every cycle are legal. Throughput is 1 access/cycle with latency 1.
- A request seen with its own response in the same cycle is granted normally. No stall is inserted.
- Reset (synchronous) sets owner=NONE and starve_cnt=0. All rvalid/gnt outputs are 0 in the cycle after RESET is sampled high.
  - Reset mid-operation: a response due in the next cycle is dropped, with no rvalid.
  - Requests are ignored while RESET=1.
- i_rdata/d_rdata hold their last value when not valid. Reset value is 0.

Optional Feature:
- Macro MISALIGN_CHECK_EN.
- Defined:
  - A D request that is half with addr[0]=1, or word with addr[1:0]≠0, is still granted (d_gnt=1) but drives mem_we=0 and mem_be=0.
  - Next cycle: d_rvalid=1, d_rdata=0, and an extra output port d_misalign=1 for that cycle (0 otherwise, 0 on reset).
- Not defined: the d_misalign port is absent. Misaligned accesses use the lane rules above with the low address bits truncated.

Test Plan:
- Single fetch:
  - Stimulus: i_req=1, i_addr=0x10; RAM word 4 = 0xDEADBEEF.
  - Response: i_gnt in N, mem_addr=0x10, i_rvalid=1, i_rdata=0xDEADBEEF in N+1.
- Store byte:
  - Stimulus: d_we=1, d_size=0, d_addr=0x23, d_wdata=0xAB.
  - Response: mem_be=4'b1000, mem_wdata=0xABABABAB, mem_addr=0x20; d_rvalid=1, d_rdata=0 next cycle.
- Contention:
  - Stimulus: i_req and d_req held high for 10 cycles; STARVE_LIMIT=4.
  - Response: D granted cycles 0-3, I granted cycle 4, starve_cnt=0 after, pattern repeats; never both grants.
- Back-to-back:
  - Stimulus: D load 0x40, then I fetch 0x44 next cycle.
  - Response: d_rvalid cycle 1, i_rvalid cycle 2, each with correct words.
- Reset mid-access:
  - Stimulus: grant D load at cycle N, RESET=1 at N.
  - Response: no d_rvalid at N+1; starve_cnt=0.
- MISALIGN_CHECK_EN:
  - Stimulus: d_size=2, d_addr=0x42, store.
  - Response: mem_we=0, mem_be=0; next cycle d_misalign=1, d_rvalid=1.
